// File: rtl/midi_pkg.sv
// Shared MIDI constants for the channel-message decoders and the voice allocator.
package midi_pkg;

    typedef enum logic [3:0] {
        ST_NOTE_OFF = 4'h8,
        ST_NOTE_ON  = 4'h9,
        ST_POLY_AT  = 4'hA,
        ST_CC       = 4'hB,
        ST_PROG     = 4'hC,
        ST_CHAN_AT  = 4'hD,
        ST_BEND     = 4'hE,
        ST_SYSTEM   = 4'hF
    } midi_status_e;

    localparam logic [6:0]  CC_SUSTAIN    = 7'd64;
    localparam logic [6:0]  CC_RESET_CTRL = 7'd121;
    localparam logic [6:0]  CC_ALL_OFF    = 7'd123;
    localparam logic [13:0] BEND_CENTER   = 14'h2000;

endpackage

// File: rtl/midi_free_voice_enc.sv
// Lowest-index priority encoder over the free-voice mask; o_any_free flags a hit.
module midi_free_voice_enc #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_free,
    output logic [IW-1:0] o_idx,
    output logic          o_any_free
);

    always_comb begin
        o_idx      = '0;
        o_any_free = |i_free;
        // Scan downward so the lowest set bit is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_free[i]) o_idx = IW'(i);
        end
    end

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic channel-message decoder: filters by channel, allocates voices
// (retrigger > free > round-robin steal), and tracks sustain, bend and CC.
module midi_voice_alloc
    import midi_pkg::*;
#(
    parameter int VOICES = 4,
    parameter bit OMNI   = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cmd_valid,
    input  logic [3:0]            chan_sel,
    input  logic [7:0]            byte1,
    input  logic [7:0]            byte2,
    input  logic [7:0]            byte3,
    output logic [VOICES-1:0]     gate,
    output logic [7*VOICES-1:0]   note_out,
    output logic [7*VOICES-1:0]   velocity_out,
    output logic [VOICES-1:0]     voice_trig,
    output logic [13:0]           bend,
    output logic [6:0]            cc_num,
    output logic [6:0]            cc_val,
    output logic                  cc_valid,
    output logic                  data_ready
);

    localparam int IW = $clog2(VOICES);

    logic [VOICES-1:0]   r_gate;
    logic [VOICES-1:0]   r_sus;
    logic [VOICES-1:0]   r_trig;
    logic [7*VOICES-1:0] r_note;
    logic [7*VOICES-1:0] r_vel;
    logic [IW-1:0]       r_steal_ptr;
    logic                r_sustain;
    logic [13:0]         r_bend;
    logic [6:0]          r_cc_num;
    logic [6:0]          r_cc_val;
    logic                r_cc_valid;
    logic                r_data_ready;

    logic [3:0]          w_status;
    logic                w_accept;
    logic                w_note_on;
    logic                w_note_off;
    logic [VOICES-1:0]   w_match_vec;
    logic                w_match_any;
    logic [IW-1:0]       w_match_idx;
    logic [IW-1:0]       w_free_idx;
    logic                w_any_free;
    logic [IW-1:0]       w_sel_idx;
    logic                w_steal;

    assign w_status   = byte1[7:4];
    assign w_accept   = cmd_valid && en && byte1[7] && (w_status != ST_SYSTEM)
                        && (OMNI || (byte1[3:0] == chan_sel));
    // Note On with zero velocity is a running-status Note Off.
    assign w_note_on  = w_accept && (w_status == ST_NOTE_ON) && (byte3[6:0] != 7'd0);
    assign w_note_off = w_accept && ((w_status == ST_NOTE_OFF) ||
                        ((w_status == ST_NOTE_ON) && (byte3[6:0] == 7'd0)));

    midi_free_voice_enc #(.N(VOICES), .IW(IW)) u_free_enc (
        .i_free     (~r_gate),
        .o_idx      (w_free_idx),
        .o_any_free (w_any_free)
    );

    always_comb begin
        w_match_vec = '0;
        w_match_idx = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            w_match_vec[i] = r_gate[i] && (r_note[7*i +: 7] == byte2[6:0]);
            if (w_match_vec[i]) w_match_idx = IW'(i);
        end
        w_match_any = |w_match_vec;
        w_steal     = !w_match_any && !w_any_free;
        if (w_match_any)     w_sel_idx = w_match_idx;
        else if (w_any_free) w_sel_idx = w_free_idx;
        else                 w_sel_idx = r_steal_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate       <= '0;
            r_sus        <= '0;
            r_trig       <= '0;
            r_note       <= '0;
            r_vel        <= '0;
            r_steal_ptr  <= '0;
            r_sustain    <= 1'b0;
            r_bend       <= BEND_CENTER;
            r_cc_num     <= '0;
            r_cc_val     <= '0;
            r_cc_valid   <= 1'b0;
            r_data_ready <= 1'b0;
        end else begin
            r_trig       <= '0;
            r_cc_valid   <= 1'b0;
            r_data_ready <= w_accept;
            if (w_note_on) begin
                r_note[7*w_sel_idx +: 7] <= byte2[6:0];
                r_vel[7*w_sel_idx +: 7]  <= byte3[6:0];
                r_gate[w_sel_idx]        <= 1'b1;
                r_sus[w_sel_idx]         <= 1'b0;
                r_trig[w_sel_idx]        <= 1'b1;
                if (w_steal) begin
                    r_steal_ptr <= (r_steal_ptr == IW'(VOICES - 1)) ? '0 : r_steal_ptr + 1'b1;
                end
            end else if (w_note_off) begin
                // Under sustain a released voice keeps sounding until the pedal lifts.
                for (int i = 0; i < VOICES; i++) begin
                    if (w_match_vec[i]) begin
                        if (r_sustain) r_sus[i]  <= 1'b1;
                        else           r_gate[i] <= 1'b0;
                    end
                end
            end else if (w_accept && (w_status == ST_CC)) begin
                r_cc_num   <= byte2[6:0];
                r_cc_val   <= byte3[6:0];
                r_cc_valid <= 1'b1;
                if (byte2[6:0] == CC_SUSTAIN) begin
                    if (byte3[6]) begin
                        r_sustain <= 1'b1;
                    end else begin
                        r_sustain <= 1'b0;
                        r_gate    <= r_gate & ~r_sus;
                        r_sus     <= '0;
                    end
                end else if (byte2[6:0] == CC_ALL_OFF) begin
                    r_gate <= '0;
                    r_sus  <= '0;
                end else if (byte2[6:0] == CC_RESET_CTRL) begin
                    r_bend    <= BEND_CENTER;
                    r_sustain <= 1'b0;
                end
            end else if (w_accept && (w_status == ST_BEND)) begin
                r_bend <= {byte3[6:0], byte2[6:0]};
            end
        end
    end

    assign gate         = r_gate;
    assign note_out     = r_note;
    assign velocity_out = r_vel;
    assign voice_trig   = r_trig;
    assign bend         = r_bend;
    assign cc_num       = r_cc_num;
    assign cc_val       = r_cc_val;
    assign cc_valid     = r_cc_valid;
    assign data_ready   = r_data_ready;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed bench for midi_voice_alloc: channel-filtered DUT plus an OMNI twin on the same inputs.
module tb_midi_voice_alloc;

    logic        clk;
    logic        rst;
    logic        en;
    logic        cmd_valid;
    logic [3:0]  chan_sel;
    logic [7:0]  byte1;
    logic [7:0]  byte2;
    logic [7:0]  byte3;

    logic [3:0]  gate,  gate_o;
    logic [27:0] note_out, note_out_o;
    logic [27:0] velocity_out, velocity_out_o;
    logic [3:0]  voice_trig, voice_trig_o;
    logic [13:0] bend, bend_o;
    logic [6:0]  cc_num, cc_num_o;
    logic [6:0]  cc_val, cc_val_o;
    logic        cc_valid, cc_valid_o;
    logic        data_ready, data_ready_o;

    int n_checks;
    int n_pass;

    midi_voice_alloc #(.VOICES(4), .OMNI(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .chan_sel(chan_sel),
        .byte1(byte1), .byte2(byte2), .byte3(byte3),
        .gate(gate), .note_out(note_out), .velocity_out(velocity_out),
        .voice_trig(voice_trig), .bend(bend), .cc_num(cc_num), .cc_val(cc_val),
        .cc_valid(cc_valid), .data_ready(data_ready)
    );

    midi_voice_alloc #(.VOICES(4), .OMNI(1'b1)) dut_omni (
        .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .chan_sel(chan_sel),
        .byte1(byte1), .byte2(byte2), .byte3(byte3),
        .gate(gate_o), .note_out(note_out_o), .velocity_out(velocity_out_o),
        .voice_trig(voice_trig_o), .bend(bend_o), .cc_num(cc_num_o), .cc_val(cc_val_o),
        .cc_valid(cc_valid_o), .data_ready(data_ready_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drive one message for one cycle; returns #1 after the capturing edge.
    task automatic send(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        @(negedge clk);
        byte1     = b1;
        byte2     = b2;
        byte3     = b3;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b0;
        en        = 1'b1;
        cmd_valid = 1'b0;
        chan_sel  = 4'd0;
        byte1     = 8'h00;
        byte2     = 8'h00;
        byte3     = 8'h00;

        // Reset values
        do_reset();
        check("rst_gate",  gate, 0);
        check("rst_note",  note_out, 0);
        check("rst_vel",   velocity_out, 0);
        check("rst_trig",  voice_trig, 0);
        check("rst_bend",  bend, 32'h2000);
        check("rst_ccnum", cc_num, 0);
        check("rst_ccval", cc_val, 0);
        check("rst_ccv",   cc_valid, 0);
        check("rst_dr",    data_ready, 0);

        // First Note On lands in voice 0 one cycle later
        send(8'h90, 8'h3C, 8'h64);
        check("on1_gate", gate, 32'h1);
        check("on1_note", note_out[6:0], 32'h3C);
        check("on1_vel",  velocity_out[6:0], 32'h64);
        check("on1_trig", voice_trig, 32'h1);
        check("on1_dr",   data_ready, 1);
        idle();
        check("on1_trig_drop", voice_trig, 0);
        check("on1_dr_drop",   data_ready, 0);

        // Fill all voices, then steal round-robin
        do_reset();
        send(8'h90, 8'h40, 8'h10);
        check("fill0_gate", gate, 32'h1);
        send(8'h90, 8'h41, 8'h11);
        check("fill1_gate", gate, 32'h3);
        send(8'h90, 8'h42, 8'h12);
        check("fill2_gate", gate, 32'h7);
        send(8'h90, 8'h43, 8'h13);
        check("fill3_gate", gate, 32'hF);
        check("fill3_notes", note_out, {4'h0, 7'h43, 7'h42, 7'h41, 7'h40});
        check("fill3_trig", voice_trig, 32'h8);
        send(8'h90, 8'h44, 8'h14);
        check("steal0_notes", note_out, {4'h0, 7'h43, 7'h42, 7'h41, 7'h44});
        check("steal0_trig", voice_trig, 32'h1);
        check("steal0_gate", gate, 32'hF);
        send(8'h90, 8'h45, 8'h15);
        check("steal1_notes", note_out, {4'h0, 7'h43, 7'h42, 7'h45, 7'h44});
        check("steal1_trig", voice_trig, 32'h2);
        // Retrigger of a held note does not move the steal pointer
        send(8'h90, 8'h42, 8'h7F);
        check("retrig_trig", voice_trig, 32'h4);
        check("retrig_vel",  velocity_out[20:14], 32'h7F);
        send(8'h90, 8'h46, 8'h16);
        check("steal2_notes", note_out, {4'h0, 7'h43, 7'h46, 7'h45, 7'h44});
        check("steal2_trig", voice_trig, 32'h4);

        // Channel filter, OMNI twin, system status and enable
        do_reset();
        send(8'h91, 8'h40, 8'h50);
        check("chan_gate",     gate, 0);
        check("chan_dr",       data_ready, 0);
        check("omni_gate",     gate_o, 32'h1);
        check("omni_dr",       data_ready_o, 1);
        check("omni_note",     note_out_o[6:0], 32'h40);
        send(8'hF0, 8'h40, 8'h50);
        check("sys_dr",        data_ready, 0);
        send(8'h50, 8'h40, 8'h50);
        check("databyte_dr",   data_ready, 0);
        en = 1'b0;
        send(8'h90, 8'h40, 8'h50);
        check("en_off_gate",   gate, 0);
        check("en_off_dr",     data_ready, 0);
        en = 1'b1;
        send(8'hA0, 8'h40, 8'h50);
        check("at_dr",         data_ready, 1);
        check("at_gate",       gate, 0);

        // Sustain pedal holds a released note until the pedal lifts
        do_reset();
        send(8'hB0, 8'h40, 8'h7F);
        check("sus_on_ccv",    cc_valid, 1);
        check("sus_on_ccnum",  cc_num, 32'h40);
        check("sus_on_ccval",  cc_val, 32'h7F);
        send(8'h90, 8'h40, 8'h64);
        check("sus_note_gate", gate, 32'h1);
        check("sus_note_ccv",  cc_valid, 0);
        send(8'h80, 8'h40, 8'h00);
        check("sus_off_gate",  gate, 32'h1);
        check("sus_off_dr",    data_ready, 1);
        send(8'hB0, 8'h40, 8'h00);
        check("sus_lift_gate", gate, 0);
        check("sus_lift_ccv",  cc_valid, 1);
        check("sus_lift_ccval", cc_val, 0);

        // Note Off without a match changes nothing
        send(8'h90, 8'h30, 8'h20);
        send(8'h80, 8'h31, 8'h00);
        check("nomatch_gate",  gate, 32'h1);
        check("nomatch_dr",    data_ready, 1);
        send(8'h80, 8'h30, 8'h00);
        check("off_gate",      gate, 0);
        check("off_keep_note", note_out[6:0], 32'h30);

        // Zero-velocity Note On releases; bend and all-notes-off
        send(8'h90, 8'h40, 8'h64);
        check("v0_pre_gate",   gate, 32'h1);
        send(8'h90, 8'h40, 8'h00);
        check("v0_gate",       gate, 0);
        check("v0_keep_vel",   velocity_out[6:0], 32'h64);
        send(8'hE0, 8'h00, 8'h40);
        check("bend_center",   bend, 32'h2000);
        send(8'hE0, 8'h7F, 8'h7F);
        check("bend_max",      bend, 32'h3FFF);
        send(8'h90, 8'h50, 8'h30);
        send(8'h90, 8'h51, 8'h31);
        check("two_gate",      gate, 32'h3);
        send(8'hB0, 8'h7B, 8'h00);
        check("alloff_gate",   gate, 0);
        check("alloff_ccnum",  cc_num, 32'h7B);
        send(8'hB0, 8'h79, 8'h00);
        check("rstctrl_bend",  bend, 32'h2000);

        // Reset wins over a same-cycle message
        send(8'h90, 8'h22, 8'h33);
        send(8'hE0, 8'h01, 8'h01);
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        byte1     = 8'h90;
        byte2     = 8'h3C;
        byte3     = 8'h64;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        check("rstcmd_gate",   gate, 0);
        check("rstcmd_note",   note_out, 0);
        check("rstcmd_trig",   voice_trig, 0);
        check("rstcmd_dr",     data_ready, 0);
        check("rstcmd_bend",   bend, 32'h2000);
        idle();
        check("rstcmd_after",  gate, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
